beam_scan_engine: RTL and testbench

- Parametrised delay-and-sum beam scanner for the mic array.
- Fires once the frequency detector reports a peak bin. Latches the FFT value at that bin for every channel, then sweeps NUM_BEAMS steering vectors and finds the beam with maximum output power.
- Reports best beam, DOA angle, peak power and a threshold-qualified valid flag to the angle display and HPS registers.
- Generalises the fixed 4-mic/37-beam weighting block: channel count, beam count, widths and memory read latency are parametrised, and it adds abort and power-threshold qualification.

---
 rtl/beam_scan_engine.sv | 247 ++++++++++++++++++++++++
 tb/tb_beam_scan_engine.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/beam_scan_engine.sv
// Delay-and-sum beam scanner: latches one FFT bin per mic, sweeps NUM_BEAMS steering
// vectors and reports the max-power beam. `define BEAM_PWR_STREAM_EN adds a per-beam power stream.
module beam_scan_engine #(
    parameter int NUM_MICS  = 4,
    parameter int NUM_BEAMS = 37,
    parameter int DATA_W    = 14,
    parameter int COEF_W    = 14,
    parameter int BIN_W     = 10,
    parameter int RD_LAT    = 2,
    parameter int ANG_MIN   = -90,
    parameter int ANG_STEP  = 5,
    localparam int PROD_W   = DATA_W + COEF_W + 1,
    localparam int ACC_W    = PROD_W + $clog2(NUM_MICS),
    localparam int PWR_W    = 2 * ACC_W + 1,
    localparam int CA_W     = $clog2(NUM_MICS * NUM_BEAMS)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         start_i,
    input  logic                         abort_i,
    input  logic [BIN_W-1:0]             bin_i,
    output logic [BIN_W-1:0]             fft_addr_o,
    input  logic [NUM_MICS*2*DATA_W-1:0] fft_q_i,
    output logic [CA_W-1:0]              coef_addr_o,
    input  logic [2*COEF_W-1:0]          coef_q_i,
    input  logic [PWR_W-1:0]             pwr_thresh_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [5:0]                   best_beam_o,
    output logic [7:0]                   doa_o,
    output logic [PWR_W-1:0]             best_pwr_o,
`ifdef BEAM_PWR_STREAM_EN
    output logic                         pwr_valid_o,
    output logic [5:0]                   pwr_beam_o,
    output logic [PWR_W-1:0]             pwr_data_o,
`endif
    output logic                         det_valid_o
);

    localparam int MIC_W = $clog2(NUM_MICS);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ISSUE, S_DRAIN, S_PWR, S_CMP, S_DONE
    } state_e;

    state_e state_q;
    logic [2:0] cnt_q;
    logic [MIC_W-1:0] mic_q;
    logic [5:0] beam_q, max_beam_q;
    logic [PWR_W-1:0] pwr_q, max_pwr_q;
    logic [NUM_MICS-1:0][DATA_W-1:0] spec_re_q, spec_im_q;

    logic [BIN_W-1:0] fft_addr_q;
    logic [CA_W-1:0] coef_addr_q;
    logic busy_q, done_q, det_valid_q;
    logic [5:0] best_beam_q;
    logic [7:0] doa_q;
    logic [PWR_W-1:0] best_pwr_q;

    // Issue tags travel alongside the ROM read so each return knows its mic
    logic [RD_LAT:1] vld_pipe_q;
    logic [RD_LAT:1][MIC_W-1:0] mic_pipe_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_pipe_q <= '0;
            mic_pipe_q <= '0;
        end else begin
            vld_pipe_q[1] <= (state_q == S_ISSUE);
            mic_pipe_q[1] <= mic_q;
            for (int k = 2; k <= RD_LAT; k++) begin
                vld_pipe_q[k] <= vld_pipe_q[k-1];
                mic_pipe_q[k] <= mic_pipe_q[k-1];
            end
        end
    end

    logic [MIC_W-1:0] ret_mic;
    logic signed [DATA_W-1:0] ar, ai;
    logic signed [COEF_W-1:0] br, bi;
    logic signed [PROD_W-1:0] ar_x, ai_x, br_x, bi_x, prod_re, prod_im;
    logic signed [ACC_W-1:0] acc_re_q, acc_im_q, acc_re_d, acc_im_d;
    logic signed [PWR_W-1:0] sq_re, sq_im;
    logic [PWR_W-1:0] pwr_d;

    always_comb begin
        ret_mic = mic_pipe_q[RD_LAT];
        ar = spec_re_q[ret_mic];
        ai = spec_im_q[ret_mic];
        br = coef_q_i[2*COEF_W-1:COEF_W];
        bi = coef_q_i[COEF_W-1:0];
        ar_x = PROD_W'(ar);
        ai_x = PROD_W'(ai);
        br_x = PROD_W'(br);
        bi_x = PROD_W'(bi);
        prod_re = ar_x * br_x - ai_x * bi_x;
        prod_im = ar_x * bi_x + ai_x * br_x;
        sq_re = PWR_W'(acc_re_q);
        sq_im = PWR_W'(acc_im_q);
        pwr_d = $unsigned(sq_re * sq_re + sq_im * sq_im);
        acc_re_d = acc_re_q;
        acc_im_d = acc_im_q;
        if (state_q == S_LOAD || state_q == S_CMP) begin
            acc_re_d = '0;
            acc_im_d = '0;
        end else if (vld_pipe_q[RD_LAT]) begin
            acc_re_d = acc_re_q + ACC_W'(prod_re);
            acc_im_d = acc_im_q + ACC_W'(prod_im);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_re_q <= '0;
            acc_im_q <= '0;
        end else begin
            acc_re_q <= acc_re_d;
            acc_im_q <= acc_im_d;
        end
    end

    // Strict compare so ties keep the lower beam; this CMP's result feeds DONE directly
    logic upd;
    logic [5:0] nbeam;
    logic [PWR_W-1:0] npwr;
    logic signed [31:0] doa_int;
    logic [7:0] doa_d;

    always_comb begin
        upd = (pwr_q > max_pwr_q);
        nbeam = upd ? beam_q : max_beam_q;
        npwr = upd ? pwr_q : max_pwr_q;
        doa_int = ANG_MIN + ANG_STEP * int'(nbeam);
        doa_d = doa_int[7:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mic_q       <= '0;
            beam_q      <= '0;
            max_beam_q  <= '0;
            max_pwr_q   <= '0;
            pwr_q       <= '0;
            spec_re_q   <= '0;
            spec_im_q   <= '0;
            fft_addr_q  <= '0;
            coef_addr_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            det_valid_q <= 1'b0;
            best_beam_q <= '0;
            best_pwr_q  <= '0;
            doa_q       <= 8'(ANG_MIN);
        end else begin
            done_q <= 1'b0;
            if (abort_i && state_q != S_IDLE) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: if (start_i && !abort_i) begin
                        fft_addr_q <= bin_i;
                        busy_q     <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= S_LOAD;
                    end
                    S_LOAD: if (cnt_q == 3'(RD_LAT)) begin
                        for (int m = 0; m < NUM_MICS; m++) begin
                            spec_re_q[m] <= fft_q_i[m*2*DATA_W+DATA_W +: DATA_W];
                            spec_im_q[m] <= fft_q_i[m*2*DATA_W +: DATA_W];
                        end
                        beam_q      <= '0;
                        mic_q       <= '0;
                        max_pwr_q   <= '0;
                        max_beam_q  <= '0;
                        coef_addr_q <= '0;
                        state_q     <= S_ISSUE;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                    // Addresses run beam-major, so the ROM address simply counts up
                    S_ISSUE: if (mic_q == MIC_W'(NUM_MICS - 1)) begin
                        cnt_q   <= '0;
                        state_q <= S_DRAIN;
                    end else begin
                        mic_q       <= mic_q + MIC_W'(1);
                        coef_addr_q <= coef_addr_q + CA_W'(1);
                    end
                    S_DRAIN: if (cnt_q == 3'(RD_LAT - 1)) begin
                        state_q <= S_PWR;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                    S_PWR: begin
                        pwr_q   <= pwr_d;
                        state_q <= S_CMP;
                    end
                    S_CMP: begin
                        max_pwr_q  <= npwr;
                        max_beam_q <= nbeam;
                        if (beam_q == 6'(NUM_BEAMS - 1)) begin
                            done_q      <= 1'b1;
                            busy_q      <= 1'b0;
                            best_beam_q <= nbeam;
                            best_pwr_q  <= npwr;
                            doa_q       <= doa_d;
                            det_valid_q <= (npwr >= pwr_thresh_i);
                            state_q     <= S_DONE;
                        end else begin
                            beam_q      <= beam_q + 6'd1;
                            mic_q       <= '0;
                            coef_addr_q <= coef_addr_q + CA_W'(1);
                            state_q     <= S_ISSUE;
                        end
                    end
                    S_DONE: state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

`ifdef BEAM_PWR_STREAM_EN
    logic pwr_valid_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) pwr_valid_q <= 1'b0;
        else         pwr_valid_q <= (state_q == S_PWR) && !abort_i;
    end

    assign pwr_valid_o = pwr_valid_q;
    assign pwr_beam_o  = beam_q;
    assign pwr_data_o  = pwr_q;
`endif

    assign fft_addr_o  = fft_addr_q;
    assign coef_addr_o = coef_addr_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign best_beam_o = best_beam_q;
    assign doa_o       = doa_q;
    assign best_pwr_o  = best_pwr_q;
    assign det_valid_o = det_valid_q;

endmodule

// File: tb/tb_beam_scan_engine.sv
// Directed bench for beam_scan_engine: default 4-mic/37-beam instance driven from a vector
// table plus corner sequences, and an 8-mic/19-beam/RD_LAT=3 instance for latency and stream.
module tb_beam_scan_engine;
    localparam int NM = 4, NB = 37, DW = 14, CW = 14, BW = 10, RL = 2;
    localparam int PW = 2 * (DW + CW + 1 + $clog2(NM)) + 1;
    localparam int CAW = $clog2(NM * NB);
    localparam int NM2 = 8, NB2 = 19, RL2 = 3;
    localparam int PW2 = 2 * (DW + CW + 1 + $clog2(NM2)) + 1;
    localparam int CAW2 = $clog2(NM2 * NB2);

    logic clk, rst_n, start, abort;
    logic [BW-1:0] bin, fft_addr;
    logic [NM*2*DW-1:0] fft_q, spec_word, junk_word;
    logic [CAW-1:0] coef_addr;
    logic [2*CW-1:0] coef_q;
    logic [PW-1:0] pwr_thresh, best_pwr;
    logic busy, done, det;
    logic [5:0] best_beam;
    logic [7:0] doa;

    logic start2, abort2;
    logic [BW-1:0] bin2, fft_addr2;
    logic [NM2*2*DW-1:0] fft_q2;
    logic [CAW2-1:0] coef_addr2;
    logic [2*CW-1:0] coef_q2;
    logic [PW2-1:0] pwr_thresh2, best_pwr2;
    logic busy2, done2, det2;
    logic [5:0] best_beam2;
    logic [7:0] doa2;
`ifdef BEAM_PWR_STREAM_EN
    logic pv1, pv2;
    logic [5:0] pb1, pb2;
    logic [PW-1:0] pd1;
    logic [PW2-1:0] pd2;
`endif

    beam_scan_engine #(.NUM_MICS(NM), .NUM_BEAMS(NB), .RD_LAT(RL)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort), .bin_i(bin),
        .fft_addr_o(fft_addr), .fft_q_i(fft_q), .coef_addr_o(coef_addr), .coef_q_i(coef_q),
        .pwr_thresh_i(pwr_thresh), .busy_o(busy), .done_o(done), .best_beam_o(best_beam),
        .doa_o(doa), .best_pwr_o(best_pwr),
`ifdef BEAM_PWR_STREAM_EN
        .pwr_valid_o(pv1), .pwr_beam_o(pb1), .pwr_data_o(pd1),
`endif
        .det_valid_o(det));

    beam_scan_engine #(.NUM_MICS(NM2), .NUM_BEAMS(NB2), .RD_LAT(RL2), .ANG_STEP(10)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start2), .abort_i(abort2), .bin_i(bin2),
        .fft_addr_o(fft_addr2), .fft_q_i(fft_q2), .coef_addr_o(coef_addr2), .coef_q_i(coef_q2),
        .pwr_thresh_i(pwr_thresh2), .busy_o(busy2), .done_o(done2), .best_beam_o(best_beam2),
        .doa_o(doa2), .best_pwr_o(best_pwr2),
`ifdef BEAM_PWR_STREAM_EN
        .pwr_valid_o(pv2), .pwr_beam_o(pb2), .pwr_data_o(pd2),
`endif
        .det_valid_o(det2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: q(t) = mem[addr(t - RD_LAT)]; FFT RAM returns junk away from the test bin
    logic [2*CW-1:0] coef_rom [NM*NB];
    logic [2*CW-1:0] coef_rom2 [NM2*NB2];
    logic [BW-1:0] cur_bin;
    logic [BW-1:0] fa_p [RL];
    logic [2*CW-1:0] cp [RL];
    logic [2*CW-1:0] cp2 [RL2];

    always @(posedge clk) begin
        fa_p[0] <= fft_addr;
        cp[0]   <= coef_rom[coef_addr];
        cp2[0]  <= coef_rom2[coef_addr2];
        for (int k = 1; k < RL; k++) begin
            fa_p[k] <= fa_p[k-1];
            cp[k]   <= cp[k-1];
        end
        for (int k = 1; k < RL2; k++) cp2[k] <= cp2[k-1];
    end

    assign fft_q   = (fa_p[RL-1] == cur_bin) ? spec_word : junk_word;
    assign coef_q  = cp[RL-1];
    assign coef_q2 = cp2[RL2-1];

    typedef struct {
        int smask, s_re, s_im;
        int c_re, c_im, hb1, hb2, hmic, h_re, h_im;
        longint thresh;
        int e_beam, e_doa;
        longint e_pwr;
        int e_det;
    } vec_t;

    vec_t vecs [8];
    int n_chk, n_fail;

    task automatic check(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [NM*2*DW-1:0] make_word(input int mask, input int re, input int im);
        logic [NM*2*DW-1:0] w;
        w = '0;
        for (int m = 0; m < NM; m++)
            if (mask[m]) w[m*2*DW +: 2*DW] = {14'(re), 14'(im)};
        return w;
    endfunction

    task automatic load_vec(input vec_t v, input int b);
        cur_bin = BW'(b);
        bin = BW'(b);
        pwr_thresh = PW'(v.thresh);
        spec_word = make_word(v.smask, v.s_re, v.s_im);
        for (int a = 0; a < NM * NB; a++) begin
            if ((a / NM == v.hb1 || a / NM == v.hb2) && (v.hmic < 0 || a % NM == v.hmic))
                coef_rom[a] = {14'(v.h_re), 14'(v.h_im)};
            else
                coef_rom[a] = {14'(v.c_re), 14'(v.c_im)};
        end
    endtask

    task automatic run_scan(input int restart_at, input int abort_at,
                            output int cyc, output int ndone, output int busy_after);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 1; ndone = 0; busy_after = 0;
        while (cyc < 400 && ndone == 0) begin
            if (done) begin
                ndone = 1;
            end else begin
                if (abort_at > 0 && cyc == abort_at + 1) busy_after = int'(busy);
                start = (cyc == restart_at);
                abort = (cyc == abort_at);
                @(posedge clk); #1;
                cyc++;
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic check_result(input string tag, input vec_t v, input int cyc);
        check({tag, " latency"}, cyc, 300);
        check({tag, " best_beam"}, best_beam, v.e_beam);
        check({tag, " doa"}, $signed(doa), v.e_doa);
        check({tag, " best_pwr"}, longint'(best_pwr), v.e_pwr);
        check({tag, " det_valid"}, det, v.e_det);
    endtask

    initial begin
        int cyc, nd, ba, np, first, last, gaps_bad;
        longint pdata9;
        n_chk = 0; n_fail = 0;
        rst_n = 1'b1; start = 1'b0; abort = 1'b0; bin = '0; pwr_thresh = '0; cur_bin = '0;
        start2 = 1'b0; abort2 = 1'b0; bin2 = '0; pwr_thresh2 = '0;
        junk_word = make_word(15, 1234, -77);
        spec_word = '0;
        for (int a = 0; a < NM * NB; a++) coef_rom[a] = '0;
        for (int a = 0; a < NM2 * NB2; a++)
            coef_rom2[a] = (a / NM2 == 9) ? {14'd1000, 14'd0} : {14'd10, 14'd0};
        fft_q2 = '0;
        for (int m = 0; m < NM2; m++) fft_q2[m*2*DW +: 2*DW] = {14'd100, 14'd0};

        vecs[0] = '{1, 1000, 0, 100, 0, 12, 12, 0, 8191, 0, 0, 12, -30, 64'd67092481000000, 1};
        vecs[1] = '{1, 1000, 0, 100, 0, 12, 12, 0, 8191, 0, 64'd67092481000001, 12, -30, 64'd67092481000000, 0};
        vecs[2] = '{1, 1000, 0, 100, 0, 12, 12, 0, 8191, 0, 64'd67092481000000, 12, -30, 64'd67092481000000, 1};
        vecs[3] = '{15, 500, -200, 100, 0, 3, 7, -1, 300, 0, 0, 3, -75, 64'd417600000000, 1};
        vecs[4] = '{0, 0, 0, 100, 0, 40, 40, -1, 0, 0, 0, 0, -90, 0, 1};
        vecs[5] = '{0, 0, 0, 100, 0, 40, 40, -1, 0, 0, 1, 0, -90, 0, 0};
        vecs[6] = '{2, 0, 1000, 0, 0, 36, 36, 1, 0, -8000, 0, 36, 90, 64'd64000000000000, 1};
        vecs[7] = '{15, -8192, -8192, 0, 0, 20, 20, -1, -8192, -8192, 0, 20, 10, 64'd288230376151711744, 1};

        #1 rst_n = 1'b0;
        #20;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset det_valid", det, 0);
        check("reset best_beam", best_beam, 0);
        check("reset best_pwr", longint'(best_pwr), 0);
        check("reset fft_addr", fft_addr, 0);
        check("reset coef_addr", coef_addr, 0);
        check("reset doa", $signed(doa), -90);
        @(posedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            load_vec(vecs[i], 37 + 5 * i);
            run_scan(-1, -1, cyc, nd, ba);
            check_result($sformatf("vec%0d", i), vecs[i], cyc);
            check($sformatf("vec%0d fft_addr", i), fft_addr, 37 + 5 * i);
            check($sformatf("vec%0d busy at done", i), busy, 0);
        end

        // Second start mid-scan must not restart anything
        load_vec(vecs[0], 200);
        run_scan(50, -1, cyc, nd, ba);
        check("restart latency", cyc, 300);
        check("restart best_beam", best_beam, 12);
        check("restart best_pwr", longint'(best_pwr), 64'd67092481000000);

        // Abort mid-scan: busy drops, no done, results keep the previous scan's values
        load_vec(vecs[3], 300);
        run_scan(-1, 120, cyc, nd, ba);
        check("abort busy next cycle", ba, 0);
        check("abort no done", nd, 0);
        check("abort best_beam held", best_beam, 12);
        check("abort best_pwr held", longint'(best_pwr), 64'd67092481000000);
        check("abort doa held", $signed(doa), -30);

        // abort and start together in IDLE: start is dropped
        @(posedge clk); #1 start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        check("abort+start busy", busy, 0);

        // Asynchronous reset during beam 1 ISSUE
        load_vec(vecs[6], 400);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (12) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midreset busy", busy, 0);
        check("midreset best_beam", best_beam, 0);
        check("midreset best_pwr", longint'(best_pwr), 0);
        check("midreset doa", $signed(doa), -90);
        check("midreset fft_addr", fft_addr, 0);
        check("midreset coef_addr", coef_addr, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        run_scan(-1, -1, cyc, nd, ba);
        check_result("after reset", vecs[6], cyc);

        // 8 mics, 19 beams, RD_LAT=3: done at 1+4+19*13 = 252
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        cyc = 1; np = 0; first = -1; last = -1; gaps_bad = 0; pdata9 = -1;
        while (cyc < 400 && !done2) begin
`ifdef BEAM_PWR_STREAM_EN
            if (pv2) begin
                if (np == 0) first = cyc;
                else if (cyc - last != 13) gaps_bad++;
                if (pb2 == 6'd9) pdata9 = longint'(pd2);
                last = cyc;
                np++;
            end
`endif
            @(posedge clk); #1;
            cyc++;
        end
        check("dut2 latency", cyc, 252);
        check("dut2 best_beam", best_beam2, 9);
        check("dut2 doa", $signed(doa2), 0);
        check("dut2 best_pwr", longint'(best_pwr2), 64'd640000000000);
`ifdef BEAM_PWR_STREAM_EN
        check("dut2 stream pulses", np, 19);
        check("dut2 stream first", first, 17);
        check("dut2 stream spacing", gaps_bad, 0);
        check("dut2 stream beam9 power", pdata9, 64'd640000000000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
